ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 144 ++++++++++++++
 tb/tb_ifetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory request, DEPTH-entry {inst, pc}
// queue toward decode, redirect flush with in-flight response discard.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        inst_ready,
  output logic [1:0]  state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [31:0]     fetch_pc, fetch_pc_n;
  logic [31:0]     req_addr, req_addr_n;
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_n;
  logic [31:0]     redir_pc;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redir_pc   = redirect_pc & ~32'h3;
  assign imem_req   = (state != IDLE);
  assign imem_addr  = req_addr;
  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign inst_pc4   = inst_pc + 32'd4;
  assign state_dbg  = state;

  // A response is kept only in WAIT and only if no redirect lands in the same cycle.
  assign push = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  always_comb begin
    count_n = count;
    if (redirect_valid)
      count_n = '0;
    else if (push && !pop)
      count_n = count + CW'(1);
    else if (pop && !push)
      count_n = count - CW'(1);
  end

  // Issuing only when count_n < DEPTH guarantees a slot: while the single
  // request is pending the queue can only drain.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_n = redir_pc;
        end else if (count_n < CW'(DEPTH)) begin
          state_n    = WAIT;
          req_addr_n = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_n = redir_pc;
          state_n    = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          fetch_pc_n = req_addr + 32'd4;
          if (count_n < CW'(DEPTH))
            req_addr_n = req_addr + 32'd4;
          else
            state_n = IDLE;
        end
      end
      DROP: begin
        if (redirect_valid)
          fetch_pc_n = redir_pc;
        if (imem_rvalid)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC & ~32'h3;
      req_addr <= RESET_PC & ~32'h3;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      count <= count_n;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_inst[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]   <= req_addr;
          wr_ptr         <= ptr_inc(wr_ptr);
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, back-pressure, redirects, reset and wrap.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic        inst_ready;
  logic [1:0]  state_dbg;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // memory model: responds once the request has been pending mem_lat edges
  logic mem_en;
  logic force_rv;
  int   mem_lat;
  int   wait_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rvalid = force_rv | (mem_en & imem_req & (wait_cnt >= mem_lat));
  assign imem_rdata  = mem_word(imem_addr);

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4),
    .inst_ready     (inst_ready),
    .state_dbg      (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!imem_req || imem_rvalid) wait_cnt <= 0;
    else                          wait_cnt <= wait_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_en = 1'b0; force_rv = 1'b0; mem_lat = 0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; mem_en = 1'b0; force_rv = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b exp 0", imem_req); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", inst_valid); else pass_cnt++;
    chk_cnt++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h exp 0", inst); else pass_cnt++;
    chk_cnt++; if (inst_pc !== 32'h0) $display("FAIL reset_pc: got %h exp 0", inst_pc); else pass_cnt++;
    chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d exp 0", state_dbg); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL release_req: got %0b exp 1", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL release_addr: got %h exp 0", imem_addr); else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset();
    mem_en = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (imem_addr !== 32'h0) $display("FAIL stream_addr0: got %h exp 0", imem_addr); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++; if (inst_valid !== 1'b1) $display("FAIL stream_valid%0d: got %0b exp 1", i, inst_valid); else pass_cnt++;
      chk_cnt++; if (inst_pc !== 32'(4 * i)) $display("FAIL stream_pc%0d: got %h exp %h", i, inst_pc, 32'(4 * i)); else pass_cnt++;
      chk_cnt++; if (inst !== mem_word(32'(4 * i))) $display("FAIL stream_inst%0d: got %h exp %h", i, inst, mem_word(32'(4 * i))); else pass_cnt++;
      chk_cnt++; if (inst_pc4 !== 32'(4 * i + 4)) $display("FAIL stream_pc4_%0d: got %h exp %h", i, inst_pc4, 32'(4 * i + 4)); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_en = 1'b1; inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL bp_full_req: got %0b exp 0", imem_req); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b1) $display("FAIL bp_full_valid: got %0b exp 1", inst_valid); else pass_cnt++;
    chk_cnt++; if (inst_pc !== 32'h0) $display("FAIL bp_head0: got %h exp 0", inst_pc); else pass_cnt++;
    inst_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (inst_pc !== 32'h4) $display("FAIL bp_head4: got %h exp 4", inst_pc); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b1) $display("FAIL bp_resume_req: got %0b exp 1", imem_req); else pass_cnt++;
    chk_cnt++; if (imem_addr !== 32'h8) $display("FAIL bp_resume_addr: got %h exp 8", imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_pc !== 32'h8) $display("FAIL bp_head8: got %h exp 8", inst_pc); else pass_cnt++;
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    bit got;
    do_reset();
    mem_en = 1'b1; mem_lat = 3; inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_cnt++; if (state_dbg !== 2'd2) $display("FAIL rw_drop_state: got %0d exp 2", state_dbg); else pass_cnt++;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rw_hold: got req %0b addr %h exp 1/0", imem_req, imem_addr); else pass_cnt++;
    repeat (2) @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL rw_discard: got req %0b valid %0b exp 0/0", imem_req, inst_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL rw_reissue: got req %0b addr %h exp 1/100", imem_req, imem_addr); else pass_cnt++;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = inst_valid;
    end
    chk_cnt++; if (!got) $display("FAIL rw_timeout: got no inst_valid exp 1 within 10 cycles"); else pass_cnt++;
    chk_cnt++; if (inst_pc !== 32'h100) $display("FAIL rw_first_pc: got %h exp 100", inst_pc); else pass_cnt++;
    chk_cnt++; if (inst !== mem_word(32'h100)) $display("FAIL rw_first_inst: got %h exp %h", inst, mem_word(32'h100)); else pass_cnt++;
  endtask

  task automatic test_redirect_full();
    do_reset();
    mem_en = 1'b1; inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk_cnt++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) $display("FAIL rf_full: got valid %0b req %0b exp 1/0", inst_valid, imem_req); else pass_cnt++;
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; force_rv = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; force_rv = 1'b0;
    chk_cnt++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rf_flush: got valid %0b req %0b exp 0/0", inst_valid, imem_req); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rf_target: got req %0b addr %h exp 1/40", imem_req, imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) $display("FAIL rf_head: got valid %0b pc %h exp 1/40", inst_valid, inst_pc); else pass_cnt++;
    // redirect coinciding with a response that would otherwise be kept
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_cnt++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rv_flush: got valid %0b req %0b exp 0/0", inst_valid, imem_req); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rv_target: got req %0b addr %h exp 1/200", imem_req, imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_pc !== 32'h200) $display("FAIL rv_head: got %h exp 200", inst_pc); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_en = 1'b1; inst_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr === 32'h0) $display("FAIL rm_pending: got req %0b addr %h exp 1/nonzero", imem_req, imem_addr); else pass_cnt++;
    rst = 1'b0; force_rv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_cnt++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) $display("FAIL rm_in_reset%0d: got valid %0b req %0b exp 0/0", i, inst_valid, imem_req); else pass_cnt++;
    end
    rst = 1'b1; force_rv = 1'b0;
    @(negedge clk);
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL rm_restart: got req %0b addr %h exp 1/0", imem_req, imem_addr); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL rm_valid: got %0b exp 0", inst_valid); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    mem_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL wrap_idle: got %0b exp 0", imem_req); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_top: got %h exp fffffffc", inst_pc); else pass_cnt++;
    chk_cnt++; if (inst_pc4 !== 32'h0) $display("FAIL wrap_pc4_top: got %h exp 0", inst_pc4); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL wrap_pc_zero: got valid %0b pc %h exp 1/0", inst_valid, inst_pc); else pass_cnt++;
    chk_cnt++; if (inst !== mem_word(32'h0)) $display("FAIL wrap_inst: got %h exp %h", inst, mem_word(32'h0)); else pass_cnt++;
    chk_cnt++; if (inst_pc4 !== 32'h4) $display("FAIL wrap_pc4_zero: got %h exp 4", inst_pc4); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; mem_en = 1'b0; force_rv = 1'b0; mem_lat = 0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_full();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
